// File: rtl/keccak_f800_iter_if.sv
// Absorb/squeeze word streams of the Keccak-f[800] engine.
// The engine uses the slave modport; the message source/result sink uses master.
interface keccak_f800_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/keccak_f800_iter.sv
// Iterative Keccak-f[800] for ProgPoW: absorbs 18 words, permutes ROUNDS_PER_CYCLE rounds per clock,
// streams 8 words back. Optional synchronous abort input enabled by `define KECCAK_F800_ABORT_EN.
module keccak_f800_iter #(
    parameter int unsigned ROUNDS           = 22,
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned IN_WORDS         = 18,
    parameter int unsigned OUT_WORDS        = 8
) (
    input  logic clk,
    input  logic rst_n,
`ifdef KECCAK_F800_ABORT_EN
    input  logic abort,
`endif
    keccak_f800_iter_if.slave bus,
    output logic busy
);

    localparam int unsigned WCNT_W = $clog2(IN_WORDS);
    localparam int unsigned RCNT_W = $clog2(ROUNDS + 1);
    localparam int unsigned OCNT_W = $clog2(OUT_WORDS);

    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(IN_WORDS - 1);
    localparam logic [RCNT_W-1:0] RCNT_DONE = RCNT_W'(ROUNDS);
    localparam logic [RCNT_W-1:0] RCNT_STEP = RCNT_W'(ROUNDS_PER_CYCLE);
    localparam logic [OCNT_W-1:0] OCNT_LAST = OCNT_W'(OUT_WORDS - 1);

    typedef logic [24:0][31:0] state_t;
    typedef enum logic [1:0] {ST_ABSORB, ST_PERMUTE, ST_SQUEEZE} fsm_t;

    fsm_t              state, state_d;
    state_t            st, st_d, permuted;
    logic [WCNT_W-1:0] wcnt, wcnt_d;
    logic [RCNT_W-1:0] rcnt, rcnt_d, rcnt_nx;
    logic [OCNT_W-1:0] ocnt, ocnt_d;

    function automatic logic [31:0] rotl(logic [31:0] x, int unsigned n);
        return (x << n) | (x >> ((32 - n) % 32));
    endfunction

    // Keccak-f[1600] rotation offsets reduced mod 32, indexed by lane x+5y
    function automatic int unsigned rho_off(int unsigned i);
        case (i)
            0:  return 0;   1:  return 1;   2:  return 30;  3:  return 28;  4:  return 27;
            5:  return 4;   6:  return 12;  7:  return 6;   8:  return 23;  9:  return 20;
            10: return 3;   11: return 10;  12: return 11;  13: return 25;  14: return 7;
            15: return 9;   16: return 13;  17: return 15;  18: return 21;  19: return 8;
            20: return 18;  21: return 2;   22: return 29;  23: return 24;  24: return 14;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] rndc(int unsigned i);
        case (i)
            0:  return 32'h00000001;  1:  return 32'h00008082;  2:  return 32'h0000808a;
            3:  return 32'h80008000;  4:  return 32'h0000808b;  5:  return 32'h80000001;
            6:  return 32'h80008081;  7:  return 32'h00008009;  8:  return 32'h0000008a;
            9:  return 32'h00000088;  10: return 32'h80008009;  11: return 32'h8000000a;
            12: return 32'h8000808b;  13: return 32'h0000008b;  14: return 32'h00008089;
            15: return 32'h00008003;  16: return 32'h00008002;  17: return 32'h00000080;
            18: return 32'h0000800a;  19: return 32'h8000000a;  20: return 32'h80008081;
            21: return 32'h00008080;
            default: return 32'h00000000;
        endcase
    endfunction

    function automatic state_t keccak_round(state_t a_in, logic [31:0] rc);
        state_t           a, b, r;
        logic [4:0][31:0] c, d;
        a = a_in;
        b = '0;
        for (int unsigned x = 0; x < 5; x++)
            c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int unsigned x = 0; x < 5; x++)
            d[x] = c[(x+4)%5] ^ rotl(c[(x+1)%5], 1);
        for (int unsigned i = 0; i < 25; i++)
            a[i] = a[i] ^ d[i%5];
        for (int unsigned x = 0; x < 5; x++)
            for (int unsigned y = 0; y < 5; y++)
                b[y + 5*((2*x + 3*y) % 5)] = rotl(a[x + 5*y], rho_off(x + 5*y));
        for (int unsigned x = 0; x < 5; x++)
            for (int unsigned y = 0; y < 5; y++)
                r[x + 5*y] = b[x + 5*y] ^ (~b[(x+1)%5 + 5*y] & b[(x+2)%5 + 5*y]);
        r[0] = r[0] ^ rc;
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ABSORB;
            st    <= '0;
            wcnt  <= '0;
            rcnt  <= '0;
            ocnt  <= '0;
        end else begin
            state <= state_d;
            st    <= st_d;
            wcnt  <= wcnt_d;
            rcnt  <= rcnt_d;
            ocnt  <= ocnt_d;
        end
    end

    always_comb begin
        state_d  = state;
        st_d     = st;
        wcnt_d   = wcnt;
        rcnt_d   = rcnt;
        ocnt_d   = ocnt;
        permuted = st;
        for (int unsigned i = 0; i < ROUNDS_PER_CYCLE; i++)
            permuted = keccak_round(permuted, rndc(32'(rcnt) + i));
        rcnt_nx = rcnt + RCNT_STEP;

        unique case (state)
            ST_ABSORB: begin
                if (bus.in_valid) begin
                    st_d[wcnt] = bus.in_data;
                    if (wcnt == WCNT_LAST) begin
                        state_d = ST_PERMUTE;
                        rcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt + 1'b1;
                    end
                end
            end
            ST_PERMUTE: begin
                st_d   = permuted;
                rcnt_d = rcnt_nx;
                if (rcnt_nx == RCNT_DONE) begin
                    state_d = ST_SQUEEZE;
                    ocnt_d  = '0;
                end
            end
            ST_SQUEEZE: begin
                if (bus.out_ready) begin
                    if (ocnt == OCNT_LAST) begin
                        state_d = ST_ABSORB;
                        st_d    = '0;
                        wcnt_d  = '0;
                        ocnt_d  = '0;
                    end else begin
                        ocnt_d = ocnt + 1'b1;
                    end
                end
            end
            default: state_d = ST_ABSORB;
        endcase

`ifdef KECCAK_F800_ABORT_EN
        // Abort overrides whatever transfer the stream ports offered this edge
        if (abort) begin
            state_d = ST_ABSORB;
            st_d    = '0;
            wcnt_d  = '0;
            rcnt_d  = '0;
            ocnt_d  = '0;
        end
`endif
    end

    assign bus.in_ready  = (state == ST_ABSORB);
    assign bus.out_valid = (state == ST_SQUEEZE);
    assign bus.out_last  = (state == ST_SQUEEZE) && (ocnt == OCNT_LAST);
    assign bus.out_data  = st[ocnt];
    assign busy          = (state != ST_ABSORB);

endmodule

// File: tb/tb_keccak_f800_iter.sv
// Directed bench for keccak_f800_iter; expected words come from a coordinate-form Keccak-f[800] model.
// Build with +define+KECCAK_F800_ABORT_EN to also exercise the abort input.
module tb_keccak_f800_iter;

    typedef logic [31:0] msg_t [18];
    typedef logic [31:0] res_t [8];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
`ifdef KECCAK_F800_ABORT_EN
    logic        abort = 1'b0;
`endif
    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;
    res_t        zero_exp;

    keccak_f800_iter_if bus();

    keccak_f800_iter #(
        .ROUNDS(22), .ROUNDS_PER_CYCLE(1), .IN_WORDS(18), .OUT_WORDS(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef KECCAK_F800_ABORT_EN
        .abort(abort),
`endif
        .bus(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference permutation in (x,y) form; offsets and round constants derived, not tabulated
    function automatic logic [31:0] m_rotl(logic [31:0] v, int n);
        if (n == 0) return v;
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic int lfsr_rc(int t);
        int r = 1;
        for (int i = 0; i < t % 255; i++) begin
            r = r << 1;
            if ((r & 32'h100) != 0) r = r ^ 32'h171;
        end
        return r & 1;
    endfunction

    task automatic model_f800(input msg_t msg, output res_t res);
        logic [31:0] a [5][5];
        logic [31:0] b [5][5];
        logic [31:0] c [5];
        logic [31:0] d [5];
        int          rho [5][5];
        int          x, y, nx;
        logic [31:0] rc;
        for (int k = 0; k < 25; k++) a[k%5][k/5] = (k < 18) ? msg[k] : 32'h0;
        rho[0][0] = 0;
        x = 1; y = 0;
        for (int t = 0; t < 24; t++) begin
            rho[x][y] = ((t + 1) * (t + 2) / 2) % 32;
            nx = y; y = (2*x + 3*y) % 5; x = nx;
        end
        for (int r = 0; r < 22; r++) begin
            for (int i = 0; i < 5; i++) c[i] = a[i][0] ^ a[i][1] ^ a[i][2] ^ a[i][3] ^ a[i][4];
            for (int i = 0; i < 5; i++) d[i] = c[(i+4)%5] ^ m_rotl(c[(i+1)%5], 1);
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) a[i][j] = a[i][j] ^ d[i];
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) b[j][(2*i + 3*j) % 5] = m_rotl(a[i][j], rho[i][j]);
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) a[i][j] = b[i][j] ^ (~b[(i+1)%5][j] & b[(i+2)%5][j]);
            rc = '0;
            for (int j = 0; j < 6; j++)
                if (lfsr_rc(j + 7*r) != 0) rc = rc | (32'h1 << ((1 << j) - 1));
            a[0][0] = a[0][0] ^ rc;
        end
        for (int k = 0; k < 8; k++) res[k] = a[k%5][k/5];
    endtask

    task automatic send_msg(input msg_t msg, output int unsigned first_cyc, output int unsigned last_cyc);
        logic        rdy;
        int unsigned budget;
        first_cyc = 0;
        for (int k = 0; k < 18; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = msg[k];
            budget = 0;
            do begin
                rdy = bus.in_ready;
                @(posedge clk); #1;
                budget++;
            end while (!rdy && budget < 400);
            if (!rdy) begin
                failures++; checks++;
                $display("FAIL send_timeout: word %0d not accepted, in_ready=%b required 1", k, rdy);
            end
            if (k == 0) first_cyc = cyc;
        end
        last_cyc = cyc;
    endtask

    task automatic recv_msg(input bit bp, output res_t got, output int unsigned last_cyc);
        int unsigned n = 0, step = 0;
        logic        v, l, rdy;
        logic [31:0] d, held = '0;
        bit          stalled = 0;
        for (int k = 0; k < 8; k++) got[k] = 'x;
        while (n < 8 && step < 400) begin
            bus.out_ready = bp ? (step % 3 == 0) : 1'b1;
            v = bus.out_valid; d = bus.out_data; l = bus.out_last; rdy = bus.out_ready;
            if (stalled) begin
                checks++;
                if (v !== 1'b1 || d !== held) begin
                    failures++;
                    $display("FAIL stall_hold: out_valid=%b out_data=%h required 1 %h", v, d, held);
                end
            end
            @(posedge clk); #1;
            step++;
            if (v && rdy) begin
                got[n] = d;
                checks++;
                if (l !== (n == 7)) begin
                    failures++;
                    $display("FAIL out_last: word %0d out_last=%b required %b", n, l, (n == 7));
                end
                n++;
                stalled = 0;
            end else if (v) begin
                stalled = 1; held = d;
            end
        end
        bus.out_ready = 1'b0;
        last_cyc = cyc;
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL recv_timeout: received %0d words required 8", n);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL after_squeeze: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++;
        if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last: got %b required 0", bus.out_last); end
        checks++;
        if (bus.out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_zero_msg;
        msg_t m; res_t got;
        int unsigned f, l, lc, lat = 0;
        for (int k = 0; k < 18; k++) m[k] = 32'h0;
        model_f800(m, zero_exp);
        send_msg(m, f, l);
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL permute_flags: busy=%b in_ready=%b required 1 0", busy, bus.in_ready);
        end
        while (!bus.out_valid && lat < 100) begin @(posedge clk); #1; lat = cyc - l; end
        checks++;
        if (lat != 22) begin failures++; $display("FAIL latency: got %0d cycles required 22", lat); end
        recv_msg(0, got, lc);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== zero_exp[k]) begin
                failures++;
                $display("FAIL zero_word%0d: got %h required %h", k, got[k], zero_exp[k]);
            end
        end
    endtask

    task automatic test_nonce_mapping;
        msg_t m, ms; res_t exp, exps, got;
        int unsigned f, l, lc;
        bit differs = 0;
        for (int k = 0; k < 8; k++) m[k] = k;
        m[8] = 32'h89ABCDEF;
        m[9] = 32'h01234567;
        for (int k = 10; k < 18; k++) m[k] = 32'hFFFFFFFF;
        ms = m; ms[8] = m[9]; ms[9] = m[8];
        model_f800(m, exp);
        model_f800(ms, exps);
        send_msg(m, f, l); bus.in_valid = 1'b0;
        recv_msg(0, got, lc);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL nonce_word%0d: got %h required %h", k, got[k], exp[k]);
            end
        end
        send_msg(ms, f, l); bus.in_valid = 1'b0;
        recv_msg(0, got, lc);
        for (int k = 0; k < 8; k++) begin
            if (got[k] !== exp[k]) differs = 1;
            checks++;
            if (got[k] !== exps[k]) begin
                failures++;
                $display("FAIL swapped_word%0d: got %h required %h", k, got[k], exps[k]);
            end
        end
        checks++;
        if (!differs) begin failures++; $display("FAIL swap_distinct: got result equal to unswapped, required different"); end
    endtask

    task automatic test_backpressure;
        msg_t m; res_t exp, got;
        int unsigned f, l, lc;
        for (int k = 0; k < 18; k++) m[k] = 32'h1000_0000 * (k % 16) + k * 32'h0001_0203;
        model_f800(m, exp);
        send_msg(m, f, l); bus.in_valid = 1'b0;
        recv_msg(1, got, lc);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                failures++;
                $display("FAIL bp_word%0d: got %h required %h", k, got[k], exp[k]);
            end
        end
    endtask

    task automatic test_ignored_input;
        msg_t m; res_t got;
        int unsigned f, l, lc, n = 0;
        for (int k = 0; k < 18; k++) m[k] = 32'h0;
        send_msg(m, f, l);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        while (!bus.out_valid && n < 100) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ignored_in_ready: got %b required 0", bus.in_ready); end
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        recv_msg(0, got, lc);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== zero_exp[k]) begin
                failures++;
                $display("FAIL ignored_word%0d: got %h required %h", k, got[k], zero_exp[k]);
            end
        end
    endtask

    task automatic test_async_reset;
        msg_t m; res_t got;
        int unsigned f, l, lc;
        for (int k = 0; k < 18; k++) m[k] = 32'h0;
        send_msg(m, f, l); bus.in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_last !== 1'b0 || bus.out_data !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: busy=%b in_ready=%b out_valid=%b out_last=%b out_data=%h required 0 1 0 0 0",
                     busy, bus.in_ready, bus.out_valid, bus.out_last, bus.out_data);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_msg(m, f, l); bus.in_valid = 1'b0;
        recv_msg(0, got, lc);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== zero_exp[k]) begin
                failures++;
                $display("FAIL post_reset_word%0d: got %h required %h", k, got[k], zero_exp[k]);
            end
        end
    endtask

    task automatic test_back_to_back;
        msg_t ma, mb; res_t ea, eb, ga, gb;
        int unsigned fa, la, fb, lb, lca, lcb;
        for (int k = 0; k < 18; k++) begin
            ma[k] = 32'hA5A5_0000 + k;
            mb[k] = 32'h0101_0101 * (k + 1);
        end
        model_f800(ma, ea);
        model_f800(mb, eb);
        fork
            begin
                send_msg(ma, fa, la);
                send_msg(mb, fb, lb);
                bus.in_valid = 1'b0;
            end
            begin
                recv_msg(0, ga, lca);
                recv_msg(0, gb, lcb);
            end
        join
        checks++;
        if (fb != lca + 1) begin
            failures++;
            $display("FAIL b2b_accept: second first-word at cycle %0d required %0d", fb, lca + 1);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (ga[k] !== ea[k]) begin failures++; $display("FAIL b2b_a_word%0d: got %h required %h", k, ga[k], ea[k]); end
            checks++;
            if (gb[k] !== eb[k]) begin failures++; $display("FAIL b2b_b_word%0d: got %h required %h", k, gb[k], eb[k]); end
        end
    endtask

`ifdef KECCAK_F800_ABORT_EN
    task automatic test_abort;
        msg_t m; res_t got;
        int unsigned f, l, lc, n = 0, taken = 0;
        for (int k = 0; k < 18; k++) m[k] = 32'h0;
        send_msg(m, f, l); bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        while (taken < 3 && n < 100) begin
            if (bus.out_valid) taken++;
            @(posedge clk); #1;
            n++;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: in_ready=%b out_valid=%b busy=%b required 1 0 0", bus.in_ready, bus.out_valid, busy);
        end
        send_msg(m, f, l); bus.in_valid = 1'b0;
        recv_msg(0, got, lc);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (got[k] !== zero_exp[k]) begin
                failures++;
                $display("FAIL abort_word%0d: got %h required %h", k, got[k], zero_exp[k]);
            end
        end
    endtask
`endif

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_zero_msg;
        test_nonce_mapping;
        test_backpressure;
        test_ignored_input;
        test_async_reset;
        test_back_to_back;
`ifdef KECCAK_F800_ABORT_EN
        test_abort;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keccak_f800_iter.md
Name: keccak_f800_iter

Overview:
Multi-cycle, stream-fed Keccak-f[800] engine for the ProgPoW hash path. It is the hardware end of the keccak_f800 operation.
- Absorbs the fixed 18-word message over a valid/ready word stream: header[8], nonce lo/hi, digest[8].
- Runs the permutation at ROUNDS_PER_CYCLE rounds per clock.
- Streams the 8 squeezed words back out on a valid/ready port, so the execution environment writes them into the header slots.

Parameters:
ROUNDS, 22, permutation rounds; iota constant index = round number 0..21.
ROUNDS_PER_CYCLE, 1, combinational rounds per clock; legal values 1, 2, 11, 22 (must divide ROUNDS).
IN_WORDS, 18, absorbed 32-bit words per message.
OUT_WORDS, 8, squeezed 32-bit words per message.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data holds an absorb word
in_ready  out  1  engine accepts an absorb word this cycle
in_data  in  32  absorb word; word k maps to lane st[k]
out_valid  out  1  out_data holds a squeeze word
out_ready  in  1  consumer takes the squeeze word this cycle
out_data  out  32  squeeze word; word k = st[k]
out_last  out  1  high with squeeze word OUT_WORDS-1
busy  out  1  high in PERMUTE and SQUEEZE

Behaviour:
- Reset (async, rst_n=0):
  - state=ABSORB; all 25 lanes=0; word counter=0; round counter=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0.
- Handshakes: a transfer occurs on a rising edge with valid&ready high.
  - in_ready and out_valid are registered and do not depend combinationally on in_valid or out_ready.
  - out_data is stable while out_valid=1 and out_ready=0.
- ABSORB:
  - in_ready=1. Each transfer writes in_data to st[wcnt], then wcnt++.
  - Lanes 18..24 stay 0.
  - Word order: 0-7 header, 8 = nonce[31:0], 9 = nonce[63:32], 10-17 digest.
  - The transfer with wcnt=IN_WORDS-1 sets state=PERMUTE, rcnt=0, in_ready=0 in the next cycle.
  - in_valid=0 means hold, with no timeout.
- PERMUTE:
  - Each cycle applies ROUNDS_PER_CYCLE rounds (theta, rho-pi, chi, iota with rndc[rcnt+i]), then rcnt += ROUNDS_PER_CYCLE.
  - Round math is 32-bit; rotation amounts are taken mod 32.
  - When rcnt reaches ROUNDS, state=SQUEEZE, ocnt=0, out_valid=1.
- SQUEEZE:
  - out_data = st[ocnt] (lane mux) and out_last = (ocnt==OUT_WORDS-1).
  - A transfer increments ocnt.
  - Transfer with out_last: clear all lanes, wcnt=0, state=ABSORB, in_ready=1, out_valid=0 next cycle.
- Latency: last absorb transfer at edge T -> out_valid=1 after edge T+ROUNDS/ROUNDS_PER_CYCLE (22 cycles for default) -> first word available.
  - Minimum message-to-message period = 18 + 22/RPC + 8 cycles.
- Boundary conditions:
  - in_valid during PERMUTE or SQUEEZE is ignored (in_ready=0) and no lane is corrupted.
  - out_ready held 0 stalls SQUEEZE indefinitely with state frozen.
  - out_ready=1 outside SQUEEZE has no effect.
  - Reset mid-ABSORB, PERMUTE or SQUEEZE: immediate return to reset values; the partial message is discarded.
  - Counters never wrap. wcnt is range 0..17, rcnt 0..22, ocnt 0..7.

Optional Feature:
Macro KECCAK_F800_ABORT_EN.
- Defined: adds input port abort (1 bit, synchronous).
  - abort=1 at any edge forces state=ABSORB, lanes=0, all counters=0, in_ready=1, out_valid=0 next cycle.
  - abort has priority over a simultaneous in or out transfer; that transfer is dropped.
- Undefined: no abort port and no abort logic. Only rst_n or completion of SQUEEZE returns the engine to ABSORB.

Test Plan:
- All-zero message, 18 words of 0x00000000, out_ready=1: out_valid rises exactly 22 cycles after the 18th transfer; 8 words equal the golden ProgPoW keccak_f800 C model output; out_last is high only on word 7.
- Nonce mapping: header=0x00000000..0x00000007, nonce=0x0123456789ABCDEF sent as word8=0x89ABCDEF and word9=0x01234567, digest=0xFFFFFFFF x8. Output matches the golden model; swapping words 8 and 9 gives a mismatch.
- Backpressure: toggle out_ready 1,0,0,1,... during SQUEEZE. out_data stays stable while stalled, each of the 8 words is seen exactly once, and then in_ready=1.
- Ignored input: hold in_valid=1 with data 0xDEADBEEF throughout PERMUTE. in_ready=0 and the result is identical to the clean run.
- Async reset pulse at round 10 of PERMUTE: outputs take reset values without waiting for a clock. A following all-zero message produces the same result as the first scenario.
- Back-to-back: two messages sent with in_valid held high; the second message's first word is accepted the cycle after the first message's out_last transfer; both results are correct. With KECCAK_F800_ABORT_EN, abort asserted at squeeze word 3 restarts cleanly.
